// File: rtl/pattern_gen.sv
// Multi-mode HDMI test-pattern source: tracks pixel coordinates from encoder
// strobes and registers one RGB pixel per read request.
module pattern_gen #(
    parameter int BPC        = 8,
    parameter int CW         = 12,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int CHECK_LOG2 = 5,
    parameter int BOX_SIZE   = 32,
    parameter int FRAME_W    = 8
) (
    input  logic                 i_pixclk,
    input  logic                 i_reset_n,
    input  logic                 i_rd,
    input  logic                 i_newline,
    input  logic                 i_newframe,
    input  logic [2:0]           i_mode,
    input  logic [3*BPC-1:0]     i_solid_rgb,
    output logic [BPC-1:0]       o_red,
    output logic [BPC-1:0]       o_grn,
    output logic [BPC-1:0]       o_blu,
    output logic                 o_valid,
    output logic [CW-1:0]        o_hcount,
    output logic [CW-1:0]        o_vcount,
    output logic [FRAME_W-1:0]   o_frame
);

    localparam logic [CW-1:0] H_LIM  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_LIM  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] BX_MAX = CW'(H_ACTIVE - BOX_SIZE);
    localparam logic [CW-1:0] BY_MAX = CW'(V_ACTIVE - BOX_SIZE);
    localparam logic [CW:0]   BOX_C  = (CW+1)'(BOX_SIZE);
    localparam logic [BPC-1:0] FS    = '1;

    logic [CW-1:0]      hcount_p0, vcount_p0;
    logic [FRAME_W-1:0] frame_p0;
    logic [2:0]         mode_p0;
    logic [CW-1:0]      bx_p0, by_p0;
    logic               dx_p0, dy_p0;   // 1 = moving toward larger coordinate
    logic [3*BPC-1:0]   pix_p0;
    logic [3*BPC-1:0]   rgb_p1;
    logic               vld_p1;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + CW'(1);
    endfunction

    // Bar boundaries are elaboration-time constants, so the bar index is a
    // chain of comparators rather than a divide.
    function automatic logic [2:0] bar_index(input logic [CW-1:0] x);
        logic [2:0] k;
        k = 3'd7;
        for (int i = 7; i >= 1; i--) begin
            if (x < CW'((H_ACTIVE * i) / 8)) k = 3'(i - 1);
        end
        return k;
    endfunction

    function automatic logic [2:0] bar_colour(input logic [2:0] k);
        case (k)
            3'd0:    return 3'b111;
            3'd1:    return 3'b110;
            3'd2:    return 3'b011;
            3'd3:    return 3'b010;
            3'd4:    return 3'b101;
            3'd5:    return 3'b100;
            3'd6:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [3*BPC-1:0] expand(input logic [2:0] c);
        return {{BPC{c[2]}}, {BPC{c[1]}}, {BPC{c[0]}}};
    endfunction

    // ---- stage p0: coordinate, frame and box state ----
    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hcount_p0 <= '0;
            vcount_p0 <= '0;
            frame_p0  <= '0;
            mode_p0   <= '0;
            bx_p0     <= '0;
            by_p0     <= '0;
            dx_p0     <= 1'b1;
            dy_p0     <= 1'b1;
        end else begin
            if (i_newline)
                hcount_p0 <= '0;
            else if (i_rd)
                hcount_p0 <= sat_inc(hcount_p0);

            if (i_newframe)
                vcount_p0 <= '0;
            else if (i_newline)
                vcount_p0 <= sat_inc(vcount_p0);

            if (i_newframe) begin
                mode_p0  <= i_mode;
                frame_p0 <= frame_p0 + FRAME_W'(1);
                // At a wall the direction flips and the position holds one frame.
                if (dx_p0 ? (bx_p0 == BX_MAX) : (bx_p0 == '0))
                    dx_p0 <= ~dx_p0;
                else
                    bx_p0 <= dx_p0 ? bx_p0 + CW'(1) : bx_p0 - CW'(1);
                if (dy_p0 ? (by_p0 == BY_MAX) : (by_p0 == '0))
                    dy_p0 <= ~dy_p0;
                else
                    by_p0 <= dy_p0 ? by_p0 + CW'(1) : by_p0 - CW'(1);
            end
        end
    end

    logic           active_p0, in_box_p0, checker_p0;
    logic [BPC-1:0] hlow_p0, flow_p0;

    always_comb begin
        active_p0  = (hcount_p0 < H_LIM) && (vcount_p0 < V_LIM);
        in_box_p0  = (hcount_p0 >= bx_p0) && ({1'b0, hcount_p0} < {1'b0, bx_p0} + BOX_C) &&
                     (vcount_p0 >= by_p0) && ({1'b0, vcount_p0} < {1'b0, by_p0} + BOX_C);
        checker_p0 = hcount_p0[CHECK_LOG2] ^ vcount_p0[CHECK_LOG2];
        hlow_p0    = hcount_p0[BPC-1:0];
        flow_p0    = BPC'(frame_p0);

        pix_p0 = '0;
        if (active_p0) begin
            case (mode_p0)
                3'd0: pix_p0 = expand(bar_colour(bar_index(hcount_p0)));
                3'd1: pix_p0 = checker_p0 ? {FS, FS, FS} : '0;
                3'd2: pix_p0 = {hlow_p0, hlow_p0, hlow_p0};
                3'd3: pix_p0 = i_solid_rgb;
                3'd4: pix_p0 = in_box_p0 ? {FS, FS, FS} : {{BPC{1'b0}}, {BPC{1'b0}}, FS};
                3'd5: pix_p0 = {flow_p0, ~flow_p0, hlow_p0};
                default: pix_p0 = '0;
            endcase
        end
    end

    // ---- stage p1: registered pixel ----
    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rgb_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= i_rd;
            if (i_rd)
                rgb_p1 <= pix_p0;
        end
    end

    assign o_red    = rgb_p1[3*BPC-1:2*BPC];
    assign o_grn    = rgb_p1[2*BPC-1:BPC];
    assign o_blu    = rgb_p1[BPC-1:0];
    assign o_valid  = vld_p1;
    assign o_hcount = hcount_p0;
    assign o_vcount = vcount_p0;
    assign o_frame  = frame_p0;

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen: table of single-pixel vectors plus
// hand-written multi-cycle sequences (reset, mode switch, strobes, box, saturation).
module tb_pattern_gen;

    logic        clk = 1'b0;
    logic        i_reset_n, i_rd, i_newline, i_newframe;
    logic [2:0]  i_mode;
    logic [23:0] i_solid_rgb;
    logic [7:0]  o_red, o_grn, o_blu, o_frame;
    logic        o_valid;
    logic [11:0] o_hcount, o_vcount;
    logic [23:0] rgb;
    logic [23:0] px [0:700];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;
    assign rgb = {o_red, o_grn, o_blu};

    pattern_gen dut (
        .i_pixclk(clk), .i_reset_n(i_reset_n), .i_rd(i_rd), .i_newline(i_newline),
        .i_newframe(i_newframe), .i_mode(i_mode), .i_solid_rgb(i_solid_rgb),
        .o_red(o_red), .o_grn(o_grn), .o_blu(o_blu), .o_valid(o_valid),
        .o_hcount(o_hcount), .o_vcount(o_vcount), .o_frame(o_frame)
    );

    typedef struct {
        logic [2:0]  mode;
        logic [23:0] solid;
        int          x;
        int          y;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs [0:18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [2:0] m);
        i_mode = m; i_newframe = 1'b1; i_newline = 1'b1;
        step();
        i_newframe = 1'b0; i_newline = 1'b0;
    endtask

    task automatic newlines(input int n);
        for (int k = 0; k < n; k++) begin
            i_newline = 1'b1;
            step();
        end
        i_newline = 1'b0;
    endtask

    task automatic read_line(input int n);
        for (int x = 0; x < n; x++) begin
            i_rd = 1'b1;
            step();
            if (x <= 700) px[x] = rgb;
        end
        i_rd = 1'b0;
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        step();
        step();
        i_reset_n = 1'b1;
        step();
    endtask

    task automatic box_check(input int n, input int bx, input int by);
        newlines(by);
        read_line(641);
        check($sformatf("box%0d left edge", n), px[bx], 24'hFFFFFF);
        check($sformatf("box%0d right edge", n), px[bx+31], 24'hFFFFFF);
        check($sformatf("box%0d past right", n), px[bx+32], (bx + 32 >= 640) ? 24'h000000 : 24'h0000FF);
        if (bx > 0) check($sformatf("box%0d before left", n), px[bx-1], 24'h0000FF);
    endtask

    initial begin
        logic [7:0]  fr;
        logic [23:0] held;
        int          bxs [0:4];
        int          bys [0:4];
        int          ns  [0:4];
        int          ci;

        vecs[0]  = '{3'd0, 24'h0,      0,   0,   24'hFFFFFF};
        vecs[1]  = '{3'd0, 24'h0,      79,  0,   24'hFFFFFF};
        vecs[2]  = '{3'd0, 24'h0,      80,  0,   24'hFFFF00};
        vecs[3]  = '{3'd0, 24'h0,      160, 0,   24'h00FFFF};
        vecs[4]  = '{3'd0, 24'h0,      240, 0,   24'h00FF00};
        vecs[5]  = '{3'd0, 24'h0,      320, 0,   24'hFF00FF};
        vecs[6]  = '{3'd0, 24'h0,      400, 0,   24'hFF0000};
        vecs[7]  = '{3'd0, 24'h0,      480, 0,   24'h0000FF};
        vecs[8]  = '{3'd0, 24'h0,      639, 0,   24'h000000};
        vecs[9]  = '{3'd1, 24'h0,      32,  0,   24'hFFFFFF};
        vecs[10] = '{3'd1, 24'h0,      32,  32,  24'h000000};
        vecs[11] = '{3'd1, 24'h0,      0,   32,  24'hFFFFFF};
        vecs[12] = '{3'd2, 24'h0,      5,   3,   24'h050505};
        vecs[13] = '{3'd2, 24'h0,      300, 1,   24'h2C2C2C};
        vecs[14] = '{3'd3, 24'h123456, 10,  2,   24'h123456};
        vecs[15] = '{3'd3, 24'h123456, 640, 2,   24'h000000};
        vecs[16] = '{3'd6, 24'h0,      10,  0,   24'h000000};
        vecs[17] = '{3'd7, 24'h123456, 10,  0,   24'h000000};
        vecs[18] = '{3'd0, 24'h0,      10,  480, 24'h000000};

        i_reset_n = 1'b1; i_rd = 1'b0; i_newline = 1'b0; i_newframe = 1'b0;
        i_mode = 3'd0; i_solid_rgb = 24'h0;
        #2 i_reset_n = 1'b0;
        #1;
        check("reset rgb", rgb, 24'h0);
        check("reset valid", o_valid, 1'b0);
        check("reset hcount", o_hcount, 12'h0);
        check("reset vcount", o_vcount, 12'h0);
        check("reset frame", o_frame, 8'h0);
        step();
        i_reset_n = 1'b1;
        step();

        for (int i = 0; i <= 18; i++) begin
            i_solid_rgb = vecs[i].solid;
            start_frame(vecs[i].mode);
            newlines(vecs[i].y);
            read_line(vecs[i].x + 1);
            check($sformatf("vec%0d mode%0d x%0d y%0d", i, vecs[i].mode, vecs[i].x, vecs[i].y),
                  px[vecs[i].x], vecs[i].exp);
        end

        // Valid tracks the read; RGB holds when there is no read.
        start_frame(3'd2);
        read_line(7);
        check("valid after read", o_valid, 1'b1);
        held = rgb;
        step();
        check("valid idle", o_valid, 1'b0);
        check("rgb hold", rgb, held);
        check("rgb held value", held, 24'h060606);

        // Asynchronous reset in the middle of a line.
        start_frame(3'd0);
        read_line(100);
        check("hcount before reset", o_hcount, 12'd100);
        #2 i_reset_n = 1'b0;
        #1;
        check("midline reset rgb", rgb, 24'h0);
        check("midline reset valid", o_valid, 1'b0);
        check("midline reset hcount", o_hcount, 12'h0);
        check("midline reset frame", o_frame, 8'h0);
        step();
        i_reset_n = 1'b1;
        step();

        // Requested mode only applies at the next frame strobe.
        start_frame(3'd0);
        i_mode = 3'd1;
        newlines(32);
        read_line(81);
        check("pending mode x32y32 bars", px[32], 24'hFFFFFF);
        check("pending mode x80 bars", px[80], 24'hFFFF00);
        start_frame(3'd1);
        read_line(33);
        check("switched x32y0", px[32], 24'hFFFFFF);
        newlines(32);
        read_line(33);
        check("switched x32y32", px[32], 24'h000000);

        // newframe + newline + rd together with hcount=5.
        start_frame(3'd2);
        newlines(1);
        read_line(5);
        fr = o_frame;
        i_mode = 3'd2; i_newframe = 1'b1; i_newline = 1'b1; i_rd = 1'b1;
        step();
        i_newframe = 1'b0; i_newline = 1'b0; i_rd = 1'b0;
        check("combo pixel x5", rgb, 24'h050505);
        check("combo valid", o_valid, 1'b1);
        check("combo hcount", o_hcount, 12'h0);
        check("combo vcount", o_vcount, 12'h0);
        check("combo frame", o_frame, fr + 8'd1);

        // Frame-colour mode.
        start_frame(3'd5);
        fr = o_frame;
        read_line(11);
        check("frame colour x10", px[10], {fr, ~fr, 8'h0A});

        // Coordinate saturation.
        i_solid_rgb = 24'h123456;
        start_frame(3'd3);
        read_line(4100);
        check("hcount saturates", o_hcount, 12'hFFF);
        check("saturated pixel black", rgb, 24'h000000);
        newlines(4100);
        check("vcount saturates", o_vcount, 12'hFFF);

        // Bouncing box: position after n frame strobes since reset.
        ns[0] = 1;   bxs[0] = 1;   bys[0] = 1;
        ns[1] = 608; bxs[1] = 608; bys[1] = 289;
        ns[2] = 609; bxs[2] = 608; bys[2] = 288;
        ns[3] = 610; bxs[3] = 607; bys[3] = 287;
        ns[4] = 700; bxs[4] = 517; bys[4] = 197;
        do_reset();
        ci = 0;
        for (int n = 1; n <= 700; n++) begin
            start_frame(3'd4);
            if (ci <= 4 && ns[ci] == n) begin
                box_check(n, bxs[ci], bys[ci]);
                ci++;
            end
        end
        check("frame after 700", o_frame, 8'd188);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
